// File: rtl/pipe_stage_reg_if.sv
// Bundle between adjacent pipeline stages: stage controls, incoming word, and the
// registered output word plus occupancy and bubble statistics.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 145,
  parameter int CNT_W  = 16
);
  logic              hold;
  logic              flush;
  logic              bubble_in;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output hold, flush, bubble_in, in_valid, in_data,
    input  out_valid, out_data, occupancy, bubble_cnt
  );

  modport slave (
    input  hold, flush, bubble_in, in_valid, in_data,
    output out_valid, out_data, occupancy, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-slot inter-stage pipeline register with hold/flush/bubble control, a DEPTH-cycle
// latency, and a saturating count of invalid words leaving the last slot.
module pipe_stage_reg #(
  parameter int DATA_W     = 145,
  parameter int DEPTH      = 1,
  parameter int CLR_BUBBLE = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_reg_if.slave   bus
);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][DATA_W-1:0] dat_q, dat_d;
  logic [3:0]                   occ_q, occ_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         in_vld;

  assign in_vld = bus.in_valid & ~bus.bubble_in;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    occ_d = '0;
    if (bus.flush) begin
      vld_d = '0;
      if (CLR_BUBBLE != 0) begin
        dat_d = '0;
      end
    end else if (!bus.hold) begin
      // The counted bubble is the word leaving the last slot on this edge.
      if (!vld_q[DEPTH-1] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
      vld_d[0] = in_vld;
      dat_d[0] = (in_vld || (CLR_BUBBLE == 0)) ? bus.in_data : '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + 4'(vld_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_valid  = vld_q[DEPTH-1];
  assign bus.out_data   = dat_q[DEPTH-1];
  assign bus.occupancy  = occ_q;
  assign bus.bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives three pipe_stage_reg configurations (DEPTH 3/2/1) against a slot-level reference
// model through a per-edge expectation queue, plus directed checks of the key scenarios.
module tb_pipe_stage_reg;
  localparam int DW = 145;

  typedef struct {
    int              k;
    logic            v;
    logic [DW-1:0]   d;
    logic [3:0]      occ;
    logic [15:0]     cnt;
  } exp_t;

  logic clk;
  logic rst     [3];
  logic hold_c  [3];
  logic flush_c [3];
  logic bub_c   [3];
  logic vld_c   [3];
  logic [DW-1:0] dat_c [3];
  logic idle    [3];

  logic          ov   [3];
  logic [DW-1:0] od   [3];
  logic [3:0]    oocc [3];
  logic [15:0]   ocnt [3];

  logic          mv [3][8];
  logic [DW-1:0] md [3][8];
  int            mcnt [3];
  exp_t          sbq [$];

  int n_vec;
  int n_err;

  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(16)) if3 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(16)) if2 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(4))  if1 ();

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(3), .CLR_BUBBLE(1), .CNT_W(16)) u3 (.clk(clk), .reset(rst[0]), .bus(if3));
  pipe_stage_reg #(.DATA_W(DW), .DEPTH(2), .CLR_BUBBLE(1), .CNT_W(16)) u2 (.clk(clk), .reset(rst[1]), .bus(if2));
  pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .CLR_BUBBLE(1), .CNT_W(4))  u1 (.clk(clk), .reset(rst[2]), .bus(if1));

  assign if3.hold = hold_c[0];  assign if3.flush = flush_c[0]; assign if3.bubble_in = bub_c[0];
  assign if3.in_valid = vld_c[0]; assign if3.in_data = dat_c[0];
  assign if2.hold = hold_c[1];  assign if2.flush = flush_c[1]; assign if2.bubble_in = bub_c[1];
  assign if2.in_valid = vld_c[1]; assign if2.in_data = dat_c[1];
  assign if1.hold = hold_c[2];  assign if1.flush = flush_c[2]; assign if1.bubble_in = bub_c[2];
  assign if1.in_valid = vld_c[2]; assign if1.in_data = dat_c[2];

  assign ov[0] = if3.out_valid; assign od[0] = if3.out_data; assign oocc[0] = if3.occupancy; assign ocnt[0] = if3.bubble_cnt;
  assign ov[1] = if2.out_valid; assign od[1] = if2.out_data; assign oocc[1] = if2.occupancy; assign ocnt[1] = if2.bubble_cnt;
  assign ov[2] = if1.out_valid; assign od[2] = if1.out_data; assign oocc[2] = if1.occupancy; assign ocnt[2] = {12'd0, if1.bubble_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int k);
    return (k == 0) ? 3 : (k == 1) ? 2 : 1;
  endfunction

  function automatic int cmax(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rnd(input int k);
    hold_c[k]  = ($urandom_range(0, 3) == 0);
    flush_c[k] = ($urandom_range(0, 5) == 0);
    bub_c[k]   = ($urandom_range(0, 3) == 0);
    vld_c[k]   = $urandom_range(0, 1) == 1;
    dat_c[k]   = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic set(input int k, input logic h, input logic f, input logic b,
                     input logic v, input logic [DW-1:0] d);
    hold_c[k] = h; flush_c[k] = f; bub_c[k] = b; vld_c[k] = v; dat_c[k] = d;
  endtask

  // Predict the post-edge state of every instance, queue it, then compare after the edge.
  task automatic tick();
    exp_t e;
    int   d;
    int   occ;
    for (int k = 0; k < 3; k++) begin
      if (idle[k]) rnd(k);
      d = dep(k);
      if (rst[k]) begin
        for (int i = 0; i < 8; i++) begin mv[k][i] = 1'b0; md[k][i] = '0; end
        mcnt[k] = 0;
      end else if (flush_c[k]) begin
        for (int i = 0; i < 8; i++) begin mv[k][i] = 1'b0; md[k][i] = '0; end
      end else if (!hold_c[k]) begin
        if (!mv[k][d-1] && (mcnt[k] < cmax(k))) mcnt[k]++;
        for (int i = d - 1; i > 0; i--) begin mv[k][i] = mv[k][i-1]; md[k][i] = md[k][i-1]; end
        mv[k][0] = vld_c[k] & ~bub_c[k];
        md[k][0] = mv[k][0] ? dat_c[k] : '0;
      end
      occ = 0;
      for (int i = 0; i < d; i++) occ += int'(mv[k][i]);
      e.k = k; e.v = mv[k][d-1]; e.d = md[k][d-1]; e.occ = 4'(occ); e.cnt = 16'(mcnt[k]);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("sb%0d.out_valid", e.k), DW'(ov[e.k]), DW'(e.v));
      check($sformatf("sb%0d.out_data", e.k), od[e.k], e.d);
      check($sformatf("sb%0d.occupancy", e.k), DW'(oocc[e.k]), DW'(e.occ));
      check($sformatf("sb%0d.bubble_cnt", e.k), DW'(ocnt[e.k]), DW'(e.cnt));
      check($sformatf("sb%0d.clr_bubble", e.k), DW'((!ov[e.k] && (od[e.k] != '0)) ? 1 : 0), '0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; idle[k] = 1'b1; mcnt[k] = 0;
      for (int i = 0; i < 8; i++) begin mv[k][i] = 1'b0; md[k][i] = '0; end
      rnd(k);
    end

    // Reset under random inputs
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check("rst.out_valid", DW'(ov[k]), '0);
      check("rst.out_data", od[k], '0);
      check("rst.occupancy", DW'(oocc[k]), '0);
      check("rst.bubble_cnt", DW'(ocnt[k]), '0);
      rst[k] = 1'b0;
    end

    // Latency through three slots
    idle[0] = 1'b0;
    set(0, 0, 0, 0, 1, 'hA); tick(); check("lat.occ1", DW'(oocc[0]), 1);
    set(0, 0, 0, 0, 1, 'hB); tick(); check("lat.occ2", DW'(oocc[0]), 2);
    set(0, 0, 0, 0, 1, 'hC); tick(); check("lat.occ3", DW'(oocc[0]), 3);
    check("lat.outA", od[0], 'hA);
    check("lat.vldA", DW'(ov[0]), 1);
    check("lat.cnt", DW'(ocnt[0]), 3);
    set(0, 0, 0, 0, 0, 'h5); tick(); check("lat.outB", od[0], 'hB);
    tick(); check("lat.outC", od[0], 'hC);

    // Flush beats hold, then flush beats bubble_in
    for (int i = 1; i <= 3; i++) begin set(0, 0, 0, 0, 1, DW'(i)); tick(); end
    set(0, 1, 1, 0, 1, 'hEE); tick();
    check("fh.occupancy", DW'(oocc[0]), 0);
    check("fh.out_valid", DW'(ov[0]), 0);
    check("fh.out_data", od[0], 0);
    for (int i = 7; i <= 9; i++) begin set(0, 0, 0, 0, 1, DW'(i)); tick(); end
    set(0, 0, 1, 1, 1, 'hEE); tick();
    check("fb.occupancy", DW'(oocc[0]), 0);

    // Reset wins over hold and flush; the next edge advances normally
    for (int i = 4; i <= 6; i++) begin set(0, 0, 0, 0, 1, DW'(i)); tick(); end
    set(0, 1, 1, 0, 1, 'hEE); rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    check("rh.occupancy", DW'(oocc[0]), 0);
    check("rh.bubble_cnt", DW'(ocnt[0]), 0);
    set(0, 0, 0, 0, 1, 'h42); tick();
    check("rh.occ_after", DW'(oocc[0]), 1);
    check("rh.cnt_after", DW'(ocnt[0]), 1);
    idle[0] = 1'b1;

    // Hold keeps a two-slot pipe frozen and never admits the held input
    idle[1] = 1'b0;
    set(1, 0, 0, 0, 1, 'h11); tick();
    set(1, 0, 0, 0, 1, 'h22); tick();
    check("hold.fill_out", od[1], 'h11);
    check("hold.fill_occ", DW'(oocc[1]), 2);
    set(1, 1, 0, 0, 1, 'hFF);
    repeat (4) begin
      tick();
      check("hold.out_data", od[1], 'h11);
      check("hold.out_valid", DW'(ov[1]), 1);
    end
    set(1, 1, 0, 1, 1, 'hFF); tick();
    check("holdbub.out_data", od[1], 'h11);
    set(1, 0, 0, 0, 0, 'hFF); tick(); check("hold.drain22", od[1], 'h22);
    tick(); check("hold.drain_vld", DW'(ov[1]), 0);
    idle[1] = 1'b1;

    // Bubble into a single-slot register, then saturation of a 4-bit counter
    idle[2] = 1'b0;
    set(2, 0, 0, 0, 0, '0); rst[2] = 1'b1; tick(); rst[2] = 1'b0;
    set(2, 0, 0, 1, 1, 'h55); tick();
    check("bub.out_valid", DW'(ov[2]), 0);
    check("bub.out_data", od[2], 0);
    check("bub.cnt", DW'(ocnt[2]), 1);
    set(2, 0, 0, 0, 1, 'h66); tick();
    check("bub.next_data", od[2], 'h66);
    check("bub.next_cnt", DW'(ocnt[2]), 2);
    set(2, 0, 0, 0, 0, 'h77);
    repeat (13) tick();
    check("sat.cnt14", DW'(ocnt[2]), 14);
    repeat (7) tick();
    check("sat.cnt15", DW'(ocnt[2]), 15);
    check("sat.out_data", od[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
